// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes, status encodings and fetch FSM states
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_HALTED} fstate_t;
endpackage

// File: rtl/instr_split.sv
// instr_split: splits a fetched byte window into Y86-64 fields, length, status and predicted PC
// FETCH_JXX_TAKEN_EN: predict conditional jumps taken
module instr_split
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 10
) (
  input  logic [8*IMEM_BYTES-1:0] rdata,
  input  logic                    err,
  input  logic [63:0]             pc,
  output logic [2:0]              stat,
  output logic [3:0]              icode,
  output logic [3:0]              ifun,
  output logic [3:0]              ra,
  output logic [3:0]              rb,
  output logic [63:0]             valc,
  output logic [63:0]             valp,
  output logic [63:0]             pred_pc
);
  logic need_regids, need_valc;
  always_comb begin
    icode = rdata[7:4];
    ifun = rdata[3:0];
    need_regids = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    need_valc = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    ra = need_regids ? rdata[15:12] : 4'hF;
    rb = need_regids ? rdata[11:8] : 4'hF;
    valc = !need_valc ? 64'h0 : need_regids ? rdata[79:16] : rdata[71:8];
    valp = pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'd0};
    stat = err ? STAT_ADR : icode > I_POPQ ? STAT_INS : icode == I_HALT ? STAT_HLT : STAT_AOK;
`ifdef FETCH_JXX_TAKEN_EN
    pred_pc = (icode == I_CALL || icode == I_JXX) ? valc : valp;
`else
    pred_pc = icode == I_CALL ? valc : valp;
`endif
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch FSM and PC register with imem handshake and redirect handling
// FETCH_JXX_TAKEN_EN (used by instr_split) selects taken prediction for conditional jumps
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic                    mispred_valid,
  input  logic [63:0]             mispred_pc,
  input  logic                    ret_valid,
  input  logic [63:0]             ret_pc,
  output logic                    imem_req,
  output logic [63:0]             imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_rvalid,
  input  logic                    imem_err,
  input  logic [8*IMEM_BYTES-1:0] imem_rdata,
  output logic                    f_valid,
  input  logic                    f_ready,
  output logic [2:0]              f_stat,
  output logic [3:0]              f_icode,
  output logic [3:0]              f_ifun,
  output logic [3:0]              f_rA,
  output logic [3:0]              f_rB,
  output logic [63:0]             f_valC,
  output logic [63:0]             f_valP,
  output logic [63:0]             f_predPC
);
  fstate_t state, state_n;
  logic [63:0] pc, pc_n, s_valc, s_valp, s_pred;
  logic [8*IMEM_BYTES-1:0] data_q;
  logic err_q, drop, drop_n, redir, take, latch;
  logic [2:0] s_stat;
  logic [3:0] s_icode, s_ifun, s_ra, s_rb;
  instr_split #(.IMEM_BYTES(IMEM_BYTES)) u_split (
    .rdata(data_q), .err(err_q), .pc(pc), .stat(s_stat), .icode(s_icode), .ifun(s_ifun),
    .ra(s_ra), .rb(s_rb), .valc(s_valc), .valp(s_valp), .pred_pc(s_pred)
  );
  always_comb begin
    redir = mispred_valid | ret_valid;
    take = state == ST_HOLD && f_ready && !stall_i;
    latch = state == ST_WAIT && imem_rvalid && !drop && !redir;
    pc_n = redir ? (mispred_valid ? mispred_pc : ret_pc) : take ? s_pred : pc;
    state_n = state;
    drop_n = drop;
    case (state)
      ST_IDLE: state_n = ST_REQ;
      // a redirect on the accepting edge leaves a stale response in flight
      ST_REQ: if (imem_ready) begin state_n = ST_WAIT; drop_n = redir; end
      ST_WAIT:
        if (imem_rvalid) begin state_n = latch ? ST_HOLD : ST_REQ; drop_n = 1'b0; end
        else if (redir) drop_n = 1'b1;
      ST_HOLD:
        if (redir) state_n = ST_REQ;
        else if (take) state_n = s_stat == STAT_AOK ? ST_REQ : ST_HALTED;
      ST_HALTED: if (redir) state_n = ST_REQ;
      default: state_n = ST_IDLE;
    endcase
  end
  always_comb begin
    imem_req = state == ST_REQ;
    imem_addr = pc;
    f_valid = state == ST_HOLD;
    f_stat = f_valid ? s_stat : STAT_AOK;
    f_icode = f_valid ? s_icode : 4'h0;
    f_ifun = f_valid ? s_ifun : 4'h0;
    f_rA = f_valid ? s_ra : 4'h0;
    f_rB = f_valid ? s_rb : 4'h0;
    f_valC = f_valid ? s_valc : 64'h0;
    f_valP = f_valid ? s_valp : 64'h0;
    f_predPC = f_valid ? s_pred : 64'h0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      if (latch) begin
        data_q <= imem_rdata;
        err_q <= imem_err;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector-table and scoreboard bench for fetch_stage with a one-outstanding imem model
module tb_fetch_stage;
  typedef struct packed {
    logic [2:0] stat; logic [3:0] icode, ifun, ra, rb; logic [63:0] valc, valp, pred;
  } out_t;
  typedef struct packed {logic [63:0] pc; logic [79:0] rdata; logic err; out_t exp;} vec_t;
`ifdef FETCH_JXX_TAKEN_EN
  localparam logic [63:0] JP4 = 64'h200, JP5 = 64'h200;
`else
  localparam logic [63:0] JP4 = 64'h19, JP5 = 64'h29;
`endif
  logic clk, rst_n, stall_i, mispred_valid, ret_valid, imem_req, imem_ready, imem_rvalid, imem_err;
  logic f_valid, f_ready, cur_err, pend, pend_err, hold_resp;
  logic [63:0] mispred_pc, ret_pc, imem_addr, f_valC, f_valP, f_predPC, a;
  logic [79:0] imem_rdata, cur_rdata, pend_data;
  logic [2:0] f_stat;
  logic [3:0] f_icode, f_ifun, f_rA, f_rB;
  int n_chk, n_fail, lat, mem_lat;
  bit vis;
  out_t sb[$];
  vec_t tv[16];
  fetch_stage #(.RESET_PC(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .mispred_valid(mispred_valid),
    .mispred_pc(mispred_pc), .ret_valid(ret_valid), .ret_pc(ret_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_err(imem_err),
    .imem_rdata(imem_rdata), .f_valid(f_valid), .f_ready(f_ready), .f_stat(f_stat),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC),
    .f_valP(f_valP), .f_predPC(f_predPC)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic out_t act();
    return {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC};
  endfunction
  function automatic vec_t mk(logic [63:0] pc, logic [79:0] rd, logic e, logic [2:0] st,
                              logic [3:0] ic, logic [3:0] fn, logic [3:0] ra, logic [3:0] rb,
                              logic [63:0] vc, logic [63:0] vp, logic [63:0] pp);
    return {pc, rd, e, st, ic, fn, ra, rb, vc, vp, pp};
  endfunction
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(output logic [63:0] addr, output bit saw_valid);
    saw_valid = 0;
    addr = 'x;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (f_valid) saw_valid = 1;
      if (imem_req) begin addr = imem_addr; return; end
    end
    n_chk++; n_fail++;
    $display("FAIL req_timeout: got no imem_req required one within 60 cycles");
  endtask
  task automatic wait_valid();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (f_valid) return;
    end
    n_chk++; n_fail++;
    $display("FAIL valid_timeout: got no f_valid required one within 60 cycles");
  endtask
  task automatic hs(input out_t e);
    sb.push_back(e);
    cyc(); f_ready = 1;
    cyc(); f_ready = 0;
  endtask
  task automatic redir_to(input vec_t v);
    cyc(); cur_rdata = v.rdata; cur_err = v.err; mispred_valid = 1; mispred_pc = v.pc;
    cyc(); mispred_valid = 0;
  endtask
  task automatic run_vec(input vec_t v);
    redir_to(v);
    wait_req(a, vis);
    chk("redir_addr", a, v.pc);
    wait_valid();
    hs(v.exp);
  endtask
  // memory model: one request at a time, response mem_lat cycles after acceptance
  initial begin
    imem_rvalid = 0; imem_rdata = '0; imem_err = 0; pend = 0; lat = 0;
    pend_data = '0; pend_err = 0;
    forever begin
      @(negedge clk);
      imem_rvalid = 0;
      if (pend && !hold_resp) begin
        if (lat == 0) begin
          imem_rvalid = 1; imem_rdata = pend_data; imem_err = pend_err; pend = 0;
        end else lat--;
      end
      if (imem_req && rst_n) begin
        n_chk++;
        if (pend || imem_rvalid) begin
          n_fail++;
          $display("FAIL overlap: got imem_req at %h with a request outstanding required none", imem_addr);
        end else if (imem_ready) begin
          pend = 1; lat = mem_lat; pend_data = cur_rdata; pend_err = cur_err;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && f_valid && f_ready && !stall_i && !mispred_valid && !ret_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_pop: got handshake %h required no output", act());
      end else chk("sb_out", act(), sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required $finish within 200000 time units");
    $fatal(1, "watchdog");
  end
  initial begin
    n_chk = 0; n_fail = 0; mem_lat = 0; hold_resp = 0;
    rst_n = 1; stall_i = 0; mispred_valid = 0; mispred_pc = 0; ret_valid = 0; ret_pc = 0;
    imem_ready = 1; f_ready = 0; cur_err = 0;
    tv[0]  = mk(64'h100, {64'h1234, 8'hF2, 8'h30}, 0, 1, 4'h3, 0, 4'hF, 4'h2, 64'h1234, 64'h10A, 64'h10A);
    tv[1]  = mk(64'h200, {72'h0, 8'h10}, 0, 1, 4'h1, 0, 4'hF, 4'hF, 0, 64'h201, 64'h201);
    tv[2]  = mk(64'h300, {64'h0, 8'h23, 8'h60}, 0, 1, 4'h6, 0, 4'h2, 4'h3, 0, 64'h302, 64'h302);
    tv[3]  = mk(64'h40, {8'h0, 64'h1000, 8'h80}, 0, 1, 4'h8, 0, 4'hF, 4'hF, 64'h1000, 64'h49, 64'h1000);
    tv[4]  = mk(64'h10, {8'h0, 64'h200, 8'h70}, 0, 1, 4'h7, 0, 4'hF, 4'hF, 64'h200, 64'h19, JP4);
    tv[5]  = mk(64'h20, {8'h0, 64'h200, 8'h74}, 0, 1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h200, 64'h29, JP5);
    tv[6]  = mk(64'h500, {64'hDEADBEEF, 8'h15, 8'h50}, 0, 1, 4'h5, 0, 4'h1, 4'h5, 64'hDEADBEEF, 64'h50A, 64'h50A);
    tv[7]  = mk(64'hFFFF_FFFF_FFFF_FFFC, {64'hAB, 8'hF0, 8'h30}, 0, 1, 4'h3, 0, 4'hF, 4'h0, 64'hAB, 64'h6, 64'h6);
    tv[8]  = mk(64'h600, {72'h0, 8'h90}, 0, 1, 4'h9, 0, 4'hF, 4'hF, 0, 64'h601, 64'h601);
    tv[9]  = mk(64'h700, {64'h0, 8'h3F, 8'hA0}, 0, 1, 4'hA, 0, 4'h3, 4'hF, 0, 64'h702, 64'h702);
    tv[10] = mk(64'h710, {64'h0, 8'h4F, 8'hB0}, 0, 1, 4'hB, 0, 4'h4, 4'hF, 0, 64'h712, 64'h712);
    tv[11] = mk(64'h800, {64'hFFFF, 8'h12, 8'hC0}, 0, 4, 4'hC, 0, 4'hF, 4'hF, 0, 64'h801, 64'h801);
    tv[12] = mk(64'h900, {72'h0, 8'hF0}, 1, 3, 4'hF, 0, 4'hF, 4'hF, 0, 64'h901, 64'h901);
    tv[13] = mk(64'hA00, {72'h0, 8'h00}, 0, 2, 4'h0, 0, 4'hF, 4'hF, 0, 64'hA01, 64'hA01);
    tv[14] = mk(64'hB00, {64'h0, 8'h67, 8'h25}, 0, 1, 4'h2, 4'h5, 4'h6, 4'h7, 0, 64'hB02, 64'hB02);
    tv[15] = mk(64'hC00, {64'h1122334455667788, 8'h89, 8'h40}, 0, 1, 4'h4, 0, 4'h8, 4'h9,
                64'h1122334455667788, 64'hC0A, 64'hC0A);
    cur_rdata = tv[0].rdata;
    #1 rst_n = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_ctl", {f_valid, imem_req, imem_addr}, {2'b00, 64'h100});
    chk("reset_out", act(), {3'd1, 208'h0});
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("idle_cycle", {imem_req, f_valid}, 2'b00);
    wait_req(a, vis);
    chk("first_addr", a, 64'h100);
    wait_valid();
    hs(tv[0].exp);
    for (int i = 1; i < 16; i++) run_vec(tv[i]);
    // redirect while the request is outstanding; stale NOP must be dropped
    cyc(); mem_lat = 4; cur_rdata = tv[1].rdata; cur_err = 0; mispred_valid = 1; mispred_pc = 64'h1000;
    cyc(); mispred_valid = 0;
    for (int k = 0; k < 20 && !pend; k++) cyc();
    cur_rdata = tv[3].rdata; mispred_valid = 1; mispred_pc = 64'h40;
    cyc(); mispred_valid = 0;
    wait_req(a, vis);
    chk("wait_redir_addr", a, 64'h40);
    chk("wait_redir_novalid", vis, 0);
    cyc(); mem_lat = 0;
    wait_valid();
    hs(tv[3].exp);
    cyc(); cur_rdata = tv[3].rdata; mispred_valid = 1; mispred_pc = 64'h40; ret_valid = 1; ret_pc = 64'h80;
    cyc(); mispred_valid = 0; ret_valid = 0;
    wait_req(a, vis);
    chk("prio_addr", a, 64'h40);
    wait_valid();
    hs(tv[3].exp);
    cyc(); imem_ready = 0; cur_rdata = tv[1].rdata; ret_valid = 1; ret_pc = 64'h200;
    cyc(); ret_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("ready_hold", {imem_req, imem_addr}, {1'b1, 64'h200});
    end
    cyc(); imem_ready = 1;
    wait_valid();
    hs(tv[1].exp);
    // redirect on the handshake edge wins over the held instruction
    redir_to(tv[1]);
    wait_valid();
    cyc(); cur_rdata = tv[2].rdata; f_ready = 1; mispred_valid = 1; mispred_pc = 64'h300;
    cyc(); f_ready = 0; mispred_valid = 0;
    wait_req(a, vis);
    chk("hs_redir_addr", a, 64'h300);
    wait_valid();
    hs(tv[2].exp);
    run_vec(tv[13]);
    repeat (5) begin
      @(negedge clk);
      chk("halted", {imem_req, f_valid}, 2'b00);
    end
    run_vec(tv[5]);
    redir_to(tv[4]);
    wait_req(a, vis);
    chk("jxx_addr", a, 64'h10);
    wait_valid();
    sb.push_back(tv[4].exp);
    cyc(); stall_i = 1; f_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out", {f_valid, act()}, {1'b1, tv[4].exp});
    end
    cyc(); stall_i = 0;
    cyc(); f_ready = 0;
    // reset in the middle of an outstanding request, stale response lands in IDLE
    cyc(); hold_resp = 1; cur_rdata = tv[6].rdata; mispred_valid = 1; mispred_pc = 64'h500;
    cyc(); mispred_valid = 0;
    for (int k = 0; k < 20 && !pend; k++) cyc();
    rst_n = 0; cur_rdata = tv[0].rdata;
    @(negedge clk);
    chk("async_reset", {imem_req, f_valid, imem_addr}, {2'b00, 64'h100});
    cyc(); cyc(); hold_resp = 0; rst_n = 1;
    @(negedge clk);
    chk("late_rvalid_idle", {imem_req, f_valid}, 2'b00);
    wait_req(a, vis);
    chk("post_reset_addr", a, 64'h100);
    chk("post_reset_novalid", vis, 0);
    wait_valid();
    hs(tv[0].exp);
    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, address fetched first after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 10, instruction window width in bytes (fixed at 10, Y86-64 maximum length).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port stall_i  in  1  hazard-unit stall; holds the fetch result and the PC.
REQ-006 SHALL have ports mispred_valid/mispred_pc  in  1/64  mispredicted jump redirect (M stage valA).
REQ-007 SHALL have ports ret_valid/ret_pc  in  1/64  return redirect (W stage valM).
REQ-008 SHALL have ports imem_req/imem_addr  out  1/64  instruction-memory request and byte address.
REQ-009 SHALL have ports imem_ready, imem_rvalid, imem_err  in  1 each  request accept, data valid, address error.
REQ-010 SHALL have port imem_rdata  in  80  little-endian bytes: byte0 = rdata[7:0].
REQ-011 SHALL have ports f_valid out 1, f_ready in 1  handshake toward the D pipeline register.
REQ-012 SHALL have outputs f_stat 3, f_icode 4, f_ifun 4, f_rA 4, f_rB 4, f_valC 64, f_valP 64, f_predPC 64.

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> WAIT -> HOLD -> REQ, plus HALTED.
REQ-014 IDLE: one cycle after reset release; next state REQ.
REQ-015 REQ: imem_req=1, imem_addr=pc; on imem_ready go to WAIT; imem_addr stable while waiting.
REQ-016 WAIT: on imem_rvalid latch rdata/err, go to HOLD; data never accepted in other states.
REQ-017 HOLD: f_valid=1; on f_ready & !stall_i, pc <= f_predPC and next state is REQ, or HALTED if f_stat != AOK.
REQ-018 Split: icode=byte0[7:4], ifun=byte0[3:0]; need_regids for icode {2,3,4,5,6,A,B}; need_valC for {3,4,5,7,8}.
REQ-019 rA/rB = byte1[7:4]/[3:0] when need_regids, else 4'hF; valC = 8 bytes from byte (1+need_regids), else 0.
REQ-020 f_valP = pc + 1 + need_regids + 8*need_valC, 64-bit wraparound.
REQ-021 f_stat codes: AOK=1, HLT=2, ADR=3, INS=4; ADR when imem_err; INS when icode > B; HLT when icode = 0; ADR has precedence over INS.
REQ-022 f_predPC = valC for CALL (8); JXX (7) per REQ-030; otherwise valP.
REQ-023 Redirect in any state: pc <= mispred_pc if mispred_valid, else ret_pc; mispred has priority when both are asserted.
REQ-024 Redirect in WAIT sets a drop flag, waits for the outstanding imem_rvalid, discards it, then goes to REQ; the FSM SHALL NOT issue a new request while one is outstanding.
REQ-025 Redirect in HOLD or HALTED: f_valid drops next cycle, and the FSM goes to REQ.
REQ-026 A redirect takes priority over a simultaneous HOLD handshake; the held instruction is dropped.
REQ-027 stall_i in HOLD keeps all outputs stable; stall_i does not block REQ or WAIT progress.

Reset
REQ-028 Reset SHALL be asynchronous: pc=RESET_PC, state=IDLE, drop=0, imem_req=0, f_valid=0, all f_* data outputs 0, f_stat=AOK.
REQ-029 Reset asserted mid-WAIT SHALL abandon the request; a late rvalid after reset release in IDLE is ignored.

Configuration
REQ-030 Macro FETCH_JXX_TAKEN_EN: when defined, JXX is predicted taken (predPC=valC); when undefined, JXX is predicted not-taken (predPC=valP). CALL is unaffected.

Structure
REQ-031 Package y86_pkg SHALL hold the icode constants (HALT..POPQ), stat encodings, and FSM state enum.
REQ-032 Combinational byte split and length logic SHALL reside in sub-module instr_split; FSM and PC register stay in fetch_stage.

Verification
REQ-033 Reset with RESET_PC=0x100; rdata byte0=0x30, byte1=0xF2, valC=0x1234 -> icode 3, rB 2, valC 0x1234, valP 0x10A, f_stat AOK.
REQ-034 Redirect while in WAIT: mispred_pc=0x40, then late rvalid -> response discarded, next imem_addr=0x40, f_valid stays 0 until the new data arrives.
REQ-035 Simultaneous mispred_pc=0x40 and ret_pc=0x80 -> next imem_addr=0x40.
REQ-036 byte0=0x00 -> f_stat HLT, FSM HALTED after the handshake, no further imem_req; mispred_pc=0x20 -> fetch resumes at 0x20.
REQ-037 imem_err=1 with byte0=0xF0 -> f_stat ADR.
REQ-038 JXX (0x70) with valC=0x200 at pc 0x10 -> f_predPC 0x200 with the macro defined, 0x19 without it; stall_i held 3 cycles in HOLD -> outputs unchanged.
